// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle for the bit-serial adder: operands and start in,
// busy/done status plus the held sum and carry out.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one LSB-first bit per clock through two cascaded half-add
// stages and a carry OR, sequenced by an IDLE/RUN/DONE controller.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_last;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_p;
  logic             w_g1;
  logic             w_s;
  logic             w_g2;
  logic             w_c_nxt;
  logic [WIDTH-1:0] w_sr_nxt;

  // 1-bit add cell on the current LSBs
  assign w_p      = r_sa[0] ^ r_sb[0];
  assign w_g1     = r_sa[0] & r_sb[0];
  assign w_s      = w_p ^ r_c;
  assign w_g2     = w_p & r_c;
  assign w_c_nxt  = w_g1 | w_g2;
  assign w_sr_nxt = {w_s, r_sr[WIDTH-1:1]};
  assign w_last   = (r_cnt == LAST);

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_RUN;
          w_load = 1'b1;
        end
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (bus.start) begin
          w_next = S_RUN;
          w_load = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sa    <= '0;
      r_sb    <= '0;
      r_sr    <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_next;
      // Status flags are registered decodes of the next state, so they are glitch-free.
      r_busy  <= (w_next == S_RUN);
      r_done  <= (w_next == S_DONE);
      if (w_load) begin
        r_sa  <= bus.a;
        r_sb  <= bus.b;
        r_sr  <= '0;
        r_c   <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_sa <= {1'b0, r_sa[WIDTH-1:1]};
        r_sb <= {1'b0, r_sb[WIDTH-1:1]};
        r_sr <= w_sr_nxt;
        r_c  <= w_c_nxt;
        // Counter parks on the last index so it never wraps mid-operation.
        if (w_last) begin
          r_sum  <= w_sr_nxt;
          r_cout <= w_c_nxt;
        end else begin
          r_cnt <= r_cnt + ONE;
        end
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 and WIDTH=4, with a
// cycle-level reference model of the request/latency/result contract.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst8;
  logic rst4;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   en8 = 1'b0;
  bit   en4 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_ctrl_if #(.WIDTH(8)) if8 ();
  serial_adder_ctrl_if #(.WIDTH(4)) if4 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(if8.slave));
  serial_adder_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4.slave));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: an accepted request yields a+b after WIDTH busy cycles.
  int       m8_left = 0, m4_left = 0;
  bit       m8_done = 0, m4_done = 0;
  bit [8:0] m8_pend = 0, m8_res = 0;
  bit [4:0] m4_pend = 0, m4_res = 0;

  always @(posedge clk) begin
    if (rst8) begin
      m8_left <= 0; m8_done <= 0; m8_res <= 0;
    end else if (m8_left > 0) begin
      m8_left <= m8_left - 1;
      if (m8_left == 1) begin
        m8_done <= 1;
        m8_res  <= m8_pend;
      end
    end else begin
      m8_done <= 0;
      if (if8.start) begin
        m8_pend <= {1'b0, if8.a} + {1'b0, if8.b};
        m8_left <= 8;
      end
    end
  end

  always @(posedge clk) begin
    if (rst4) begin
      m4_left <= 0; m4_done <= 0; m4_res <= 0;
    end else if (m4_left > 0) begin
      m4_left <= m4_left - 1;
      if (m4_left == 1) begin
        m4_done <= 1;
        m4_res  <= m4_pend;
      end
    end else begin
      m4_done <= 0;
      if (if4.start) begin
        m4_pend <= {1'b0, if4.a} + {1'b0, if4.b};
        m4_left <= 4;
      end
    end
  end

  always @(negedge clk) begin
    if (en8) begin
      chk("w8_busy", 64'(if8.busy), 64'(m8_left > 0));
      chk("w8_done", 64'(if8.done), 64'(m8_done));
      chk("w8_result", 64'({if8.cout, if8.sum}), 64'(m8_res));
    end
    if (en4) begin
      chk("w4_busy", 64'(if4.busy), 64'(m4_left > 0));
      chk("w4_done", 64'(if4.done), 64'(m4_done));
      chk("w4_result", 64'({if4.cout, if4.sum}), 64'(m4_res));
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] esum, input logic ecout, input string nm);
    int t0;
    int nbusy;
    bit seen;
    if8.a = a; if8.b = b; if8.start = 1'b1;
    t0 = cyc;
    nbusy = 0;
    seen = 0;
    @(negedge clk);
    if8.start = 1'b0;
    chk({nm, "_busy_after_start"}, 64'(if8.busy), 64'(1));
    for (int i = 0; i < 20 && !seen; i++) begin
      if (if8.busy) nbusy++;
      if (if8.done) begin
        seen = 1;
        chk({nm, "_latency"}, 64'(cyc - t0), 64'(9));
        chk({nm, "_busy_cycles"}, 64'(nbusy), 64'(8));
        chk({nm, "_sum"}, 64'(if8.sum), 64'(esum));
        chk({nm, "_cout"}, 64'(if8.cout), 64'(ecout));
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) chk({nm, "_done_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic count_done8(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (if8.done) dones++;
    end
  endtask

  initial begin
    int dones;
    int k;
    int last;
    bit fin;
    rst8 = 1'b1; rst4 = 1'b1;
    if8.start = 1'b1; if8.a = 8'h00; if8.b = 8'h00;
    if4.start = 1'b0; if4.a = 4'h0; if4.b = 4'h0;

    // Reset with start held: reset must win.
    @(negedge clk);
    en8 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(if8.busy), 64'(0));
    chk("rst_done", 64'(if8.done), 64'(0));
    chk("rst_sum", 64'({if8.cout, if8.sum}), 64'(0));
    rst8 = 1'b0; if8.start = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(if8.busy), 64'(0));

    op8(8'h00, 8'h00, 8'h00, 1'b0, "zero");
    @(negedge clk);
    op8(8'hFF, 8'h01, 8'h00, 1'b1, "ripple");
    @(negedge clk);
    op8(8'hA5, 8'h5A, 8'hFF, 1'b0, "nocarry");
    @(negedge clk);

    // Start during RUN is ignored.
    if8.a = 8'h0F; if8.b = 8'h01; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if8.a = 8'hFF; if8.b = 8'hFF; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      if (if8.done) begin
        dones++;
        chk("ignored_sum", 64'({if8.cout, if8.sum}), 64'(9'h010));
      end
      @(negedge clk);
    end
    chk("ignored_done_count", 64'(dones), 64'(1));

    // Reset mid-RUN aborts.
    if8.a = 8'h80; if8.b = 8'h80; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    chk("abort_busy", 64'(if8.busy), 64'(0));
    chk("abort_sum", 64'({if8.cout, if8.sum}), 64'(0));
    count_done8(12, dones);
    chk("abort_no_done", 64'(dones), 64'(0));
    op8(8'h80, 8'h80, 8'h00, 1'b1, "after_abort");

    // Back-to-back: next start issued in the DONE cycle.
    @(negedge clk);
    op8(8'h01, 8'h02, 8'h03, 1'b0, "b2b_first");
    op8(8'h7F, 8'h01, 8'h80, 1'b0, "b2b_second");
    @(negedge clk);
    @(negedge clk);
    chk("held_sum", 64'({if8.cout, if8.sum}), 64'(9'h080));

    // WIDTH=4 exhaustive with start held high throughout.
    @(negedge clk);
    en4 = 1'b1;
    rst4 = 1'b0;
    if4.a = 4'h0; if4.b = 4'h0; if4.start = 1'b1;
    k = 0; last = 0; fin = 0;
    for (int i = 0; i < 256 * 5 + 40 && !fin; i++) begin
      @(negedge clk);
      if (if4.done) begin
        chk("w4_pair_result", 64'({if4.cout, if4.sum}), 64'((k >> 4) + (k & 15)));
        if (k > 0) chk("w4_interval", 64'(cyc - last), 64'(5));
        last = cyc;
        k++;
        if (k < 256) begin
          if4.a = 4'(k >> 4); if4.b = 4'(k & 15);
        end else begin
          if4.start = 1'b0;
          fin = 1;
        end
      end
    end
    chk("w4_pairs_completed", 64'(k), 64'(256));
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder with a sequencing controller. It accepts two WIDTH-bit operands on a start strobe and adds them one bit per clock through a single 1-bit add cell: two cascaded half-add stages plus a carry OR. It shifts the result into a register and signals completion with a one-cycle done pulse. It replaces a WIDTH-wide ripple adder where area matters more than latency, and is the sequencing layer above the existing half-adder datapath.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset; one clock, one reset domain
- start  in  1  request strobe; sampled only when busy=0
- a  in  WIDTH  operand A; captured on an accepted start
- b  in  WIDTH  operand B; captured on an accepted start
- busy  out  1  high while an addition is in progress (RUN state)
- done  out  1  one-cycle pulse; sum and cout are valid in this cycle
- sum  out  WIDTH  result; holds its value until the next completion or reset
- cout  out  1  final carry out; holds with sum

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: one bit-add per cycle.
  - DONE: result presented.
- IDLE -> RUN on start=1. In the same edge: a and b are loaded into shift registers sa and sb, carry register c is cleared to 0, bit counter cnt is cleared to 0, and the result shift register sr is cleared.
- RUN, every cycle:
  - Half-add stage 1: p = sa[0]^sb[0], g1 = sa[0]&sb[0].
  - Half-add stage 2: s = p^c, g2 = p&c.
  - Carry update: c <= g1|g2.
  - Shifts: sa and sb shift right one bit (MSB filled with 0); sr shifts right with s entering at sr[WIDTH-1].
  - Counter: cnt <= cnt+1.
- RUN -> DONE when cnt==WIDTH-1 and that cycle's bit has been processed. In that edge, sum is loaded with the final sr value (including that cycle's bit) and cout is loaded with the final carry.
- DONE -> RUN if start=1: operands are re-captured exactly as from IDLE, giving back-to-back operation. Otherwise DONE -> IDLE.
- start is ignored in RUN. Operands and the in-flight result are unaffected. No error flag.
- Arithmetic: unsigned modulo 2^WIDTH. {cout,sum} = a+b exactly, for every operand pair.
- cnt width is clog2(WIDTH). It must never wrap inside an operation.
- a and b are don't-care except on the accepting edge.

## Timing
- Reset values (rst=1 at a rising edge):
  - State: IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - sa, sb, sr, c, cnt all cleared.
- Reset overrides start in the same cycle.
- Reset mid-RUN aborts the addition. sum/cout are cleared and no done is produced.
- busy = (state==RUN) and done = (state==DONE). Both are registered state decodes and free of glitches.
- Latency: start accepted at edge t. busy is high for cycles t+1 .. t+WIDTH. done is high in cycle t+WIDTH+1 only. sum/cout are valid from t+WIDTH+1 and held after that.
- Throughput: with start held high in every DONE cycle, one result every WIDTH+1 cycles.
- Within an addition, LSB is processed first: bit i is processed in the cycle starting at t+1+i.
- sum/cout change only on a RUN->DONE transition or on reset. They do not change during RUN.

## Test plan
- Reset with start=1 held, then release; WIDTH=8, a=8'h00, b=8'h00, start pulse -> busy high for exactly 8 cycles, done exactly 9 cycles after the start edge, sum=8'h00, cout=0.
- a=8'hFF, b=8'h01 (full carry ripple) -> sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A -> sum=8'hFF, cout=0 (no carries).
- Pulse start with a=8'h0F, b=8'h01; at cycle 3 of RUN pulse start with a=8'hFF, b=8'hFF -> second request ignored, result sum=8'h10, cout=0, only one done pulse.
- Assert rst in cycle 4 of RUN with a=8'h80, b=8'h80 -> next cycle busy=0, sum=0, cout=0, no done. A subsequent start with a=8'h80, b=8'h80 completes normally -> sum=8'h00, cout=1.
- Back-to-back: start asserted in the DONE cycle with new operands 8'h7F+8'h01 -> RUN re-entered with no IDLE cycle, next done 9 cycles later, sum=8'h80, cout=0. The previous sum is held until then.
- WIDTH=4, exhaustive over all 256 operand pairs -> {cout,sum}==a+b for each, done interval exactly 5 cycles.
